rv32i_mem_arbiter: RTL

Shares the single unified memory port of the RV32I core between the instruction-fetch requester (I, read-only) and the load/store requester (D, read/write with byte enables). One transaction is in flight at a time. D has priority, and a bounded-streak rule prevents fetch starvation. Sits between the core's IF/MEM stages and the memory model instantiated in the core's simulation bench.

---
 rtl/rv32i_mem_pkg.sv | 21 ++
 rtl/mem_arb_pick.sv | 30 +++
 rtl/rv32i_mem_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rv32i_mem_pkg.sv
// Shared encodings for the RV32I unified memory-port arbiter.
// Owner values are fixed because the bench and future requesters rely on them.
package rv32i_mem_pkg;

    localparam int unsigned STREAK_W = 4;

    // Clears the byte offset; sliced to the address width at the use site.
    localparam logic [63:0] WORD_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: D has priority unless the I-starvation streak
// has reached its limit while a fetch is waiting.
module mem_arb_pick
    import rv32i_mem_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic                i_req,
    input  logic                d_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                valid,
    output owner_e              winner
);

    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_STREAK);

    logic i_forced;

    assign i_forced = i_req && (streak == STREAK_LIMIT);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        valid  = i_req | d_req;
        winner = OWN_I;
        if (d_req && !i_forced) begin
            winner = OWN_D;
        end
    end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D), one transaction
// in flight, with re-arbitration on the response cycle for back-to-back issue.
module rv32i_mem_arbiter
    import rv32i_mem_pkg::*;
#(
    parameter int MAX_STREAK = 4,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_be,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata
);

    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_STREAK);
    localparam logic [AW-1:0]       ADDR_MASK    = WORD_MASK[AW-1:0];

    arb_state_e          state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic   arb_point;
    logic   pick_valid;
    owner_e pick_winner;

    mem_arb_pick #(
        .MAX_STREAK(MAX_STREAK)
    ) u_pick (
        .i_req (i_req),
        .d_req (d_req),
        .streak(streak_q),
        .valid (pick_valid),
        .winner(pick_winner)
    );

    // Arbitration points: IDLE, and WAIT on the response cycle.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        streak_d  = streak_q;
        arb_point = 1'b0;

        unique case (state_q)
            ST_IDLE:  arb_point = 1'b1;
            ST_ISSUE: if (mem_gnt) state_d = ST_WAIT;
            ST_WAIT:  arb_point = mem_rvalid;
            default:  state_d = ST_IDLE;
        endcase

        if (arb_point) begin
            if (pick_valid) begin
                state_d = ST_ISSUE;
                owner_d = pick_winner;
            end else begin
                state_d = ST_IDLE;
            end

            // With i_req high a winner always exists, so the else branch is a D win over a waiting fetch.
            if (!i_req || pick_winner == OWN_I) begin
                streak_d = '0;
            end else if (streak_q != STREAK_LIMIT) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_I;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end

    logic in_issue, in_wait, own_d;

    assign in_issue = (state_q == ST_ISSUE);
    assign in_wait  = (state_q == ST_WAIT);
    assign own_d    = (owner_q == OWN_D);

    // Fields are zeroed outside ISSUE; fetches are always full-word reads.
    assign mem_req   = in_issue;
    assign mem_we    = in_issue & own_d & d_we;
    assign mem_addr  = in_issue ? ((own_d ? d_addr : i_addr) & ADDR_MASK) : '0;
    assign mem_wdata = (in_issue & own_d & d_we) ? d_wdata : 32'h0;
    assign mem_be    = in_issue ? ((own_d & d_we) ? d_be : 4'b1111) : 4'b0000;

    assign i_gnt     = in_issue & ~own_d & mem_gnt;
    assign d_gnt     = in_issue &  own_d & mem_gnt;

    assign i_rvalid  = in_wait & ~own_d & mem_rvalid;
    assign d_rvalid  = in_wait &  own_d & mem_rvalid;
    assign i_rdata   = (in_wait & ~own_d) ? mem_rdata : 32'h0;
    assign d_rdata   = (in_wait &  own_d) ? mem_rdata : 32'h0;

endmodule
